// File: rtl/bp_stream_to_lite.sv
// bp_stream_to_lite
//
// Deserializer that turns a BedRock memory stream into one wide BedRock Lite
// message. The stream delivers a header plus one narrow data beat per
// handshake, and a last flag. Only one message is buffered at a time.
//
// The header layout is {payload, size[2:0], addr[paddr-1:0], msg_type[3:0]}.
// msg_type sits at the LSBs. The payload field is lce_id plus way id.
//
// Ports
//   clk_i         rising-edge clock
//   reset_n_i     asynchronous active-low reset
//   mem_header_i  stream header (addr advances per beat)
//   mem_data_i    stream beat data
//   mem_v_i       beat valid
//   mem_ready_o   beat ready (registered)
//   mem_last_i    final beat of the message
//   mem_o         assembled Lite message {header, data}
//   mem_v_o       message valid (registered)
//   mem_ready_i   sink ready
//
// Optional build macro BP_STREAM_TO_LITE_REPLICATE_EN.
//   When defined, beats fill slots 0..N-1 in arrival order. The N-slot block
//   is then replicated across the output data.
//   When undefined, each beat lands in the slot given by its own address.
module bp_stream_to_lite
  #(parameter int paddr_width_p            = 40
  , parameter int lce_id_width_p           = 4
  , parameter int lce_assoc_p              = 8
  , parameter int in_data_width_p          = 64
  , parameter int out_data_width_p         = 512
  , parameter logic [15:0] payload_mask_p  = '0
  , localparam int payload_width_lp  = lce_id_width_p + $clog2(lce_assoc_p)
  , localparam int header_width_lp   = payload_width_lp + 3 + paddr_width_p + 4
  , localparam int msg_width_lp      = header_width_lp + out_data_width_p
  )
  (input  logic                        clk_i
  , input  logic                       reset_n_i
  , input  logic [header_width_lp-1:0] mem_header_i
  , input  logic [in_data_width_p-1:0] mem_data_i
  , input  logic                       mem_v_i
  , output logic                       mem_ready_o
  , input  logic                       mem_last_i
  , output logic [msg_width_lp-1:0]    mem_o
  , output logic                       mem_v_o
  , input  logic                       mem_ready_i
  );

  localparam int stream_words_lp = out_data_width_p / in_data_width_p;
  localparam int offset_lp       = $clog2(in_data_width_p / 8);
  localparam int cnt_width_lp    = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;

  typedef enum logic {e_collect, e_send} state_e;

  state_e state_q, state_d;
  logic   ready_q, v_q;
  // One bit wider than a slot index, so that it can hold the full beat count N.
  logic [cnt_width_lp:0]          cnt_q, cnt_d;
  logic [header_width_lp-1:0]     header_q;
  logic [out_data_width_p-1:0]    buf_flat;
  logic [out_data_width_p-1:0]    data_out;
  logic [cnt_width_lp-1:0]        wr_slot;
  logic                           clear;

  wire [3:0]               in_msg_type = mem_header_i[3:0];
  wire [paddr_width_p-1:0] in_addr     = mem_header_i[4 +: paddr_width_p];
  wire                     is_payload  = payload_mask_p[in_msg_type];
  wire                     accept      = ready_q & mem_v_i;
  wire                     final_slot  = (cnt_q == (cnt_width_lp+1)'(stream_words_lp - 1));
  // An overrun beat (the buffer is full but last is not set) closes the message.
  wire                     last_beat   = accept & (mem_last_i | final_slot);

`ifdef BP_STREAM_TO_LITE_REPLICATE_EN
  assign wr_slot = (stream_words_lp == 1) ? '0 : cnt_q[cnt_width_lp-1:0];
`else
  assign wr_slot = (stream_words_lp == 1) ? '0 : in_addr[offset_lp +: cnt_width_lp];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    case (state_q)
      e_collect: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = e_send;
        end
      end
      e_send: begin
        if (mem_ready_i) begin
          state_d = e_collect;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      default: state_d = e_collect;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_collect;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      v_q      <= 1'b0;
      header_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Handshake flags come from the next state, so both stay registered.
      ready_q <= (state_d == e_collect);
      v_q     <= (state_d == e_send);
      if (accept && (cnt_q == '0)) header_q <= mem_header_i;
    end
  end

`ifdef BP_STREAM_TO_LITE_REPLICATE_EN
  // N is a power of two, so "slot mod N" reduces to a mask of N-1.
  logic [cnt_width_lp:0]   cnt_m1;
  logic [cnt_width_lp-1:0] rep_mask;
  assign cnt_m1   = cnt_q - 1'b1;
  assign rep_mask = cnt_m1[cnt_width_lp-1:0];
`endif

  for (genvar gi = 0; gi < stream_words_lp; gi++) begin : g_slot
    localparam logic [cnt_width_lp-1:0] slot_lp = cnt_width_lp'(gi);
    logic [in_data_width_p-1:0] slot_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)                                   slot_q <= '0;
      else if (clear)                                   slot_q <= '0;
      else if (accept && is_payload && wr_slot == slot_lp) slot_q <= mem_data_i;
    end

    assign buf_flat[gi*in_data_width_p +: in_data_width_p] = slot_q;

`ifdef BP_STREAM_TO_LITE_REPLICATE_EN
    wire [cnt_width_lp-1:0] src_slot = slot_lp & rep_mask;
    assign data_out[gi*in_data_width_p +: in_data_width_p] =
      buf_flat[src_slot*in_data_width_p +: in_data_width_p];
`else
    assign data_out[gi*in_data_width_p +: in_data_width_p] = slot_q;
`endif
  end

  assign mem_ready_o = ready_q;
  assign mem_v_o     = v_q;
  assign mem_o       = {header_q, data_out};

  always @(posedge clk_i) begin
    if (reset_n_i)
      assert (!(accept && final_slot && !mem_last_i))
        else $error("bp_stream_to_lite: stream overrun without last flag");
  end

endmodule

// File: doc/bp_stream_to_lite.md
# bp_stream_to_lite

Deserializing stage that consumes a BedRock memory stream (header plus narrow data beat per handshake, with a last flag) and reassembles it into a single wide BedRock Lite message. It sits directly downstream of the lite-to-stream serializer, or of any network endpoint emitting BedRock streams. It hands whole-block messages to Lite-only clients such as the CCE, configuration, or cache-fill logic. One message is buffered at a time.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- in_data_width_p, "inv": stream beat data width; power of two, at least 8.
- out_data_width_p, "inv": Lite message data width; a multiple of in_data_width_p.
- payload_mask_p, 0: bit i set means msg_type i carries data.
- Derived:
  - stream_words_lp = out_data_width_p/in_data_width_p
  - offset_lp = clog2(in_data_width_p/8)
  - cnt_width_lp = safe_clog2(stream_words_lp)
- clk_i  in  1  clock; all state is rising-edge.
- reset_n_i  in  1  asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronised externally.
- mem_header_i  in  in_mem_msg_header_width  stream header; addr auto-increments per beat.
- mem_data_i  in  in_data_width_p  beat data.
- mem_v_i  in  1  beat valid.
- mem_ready_o  out  1  beat ready. Handshake is ready-valid-and.
- mem_last_i  in  1  final beat of the message; qualified by mem_v_i.
- mem_o  out  out_mem_msg_width  assembled Lite message as {header, data}.
- mem_v_o  out  1  message valid.
- mem_ready_i  in  1  sink ready. Handshake is ready-valid-and.

## Operation
- FSM has two states:
  - e_collect (reset state): mem_ready_o=1.
  - e_send: mem_ready_o=0, mem_v_o=1.
- First beat of a message (beat counter == 0):
  - The full header is captured, including the original addr, size and msg_type.
  - The beat's addr is the unmodified message address.
- Every accepted beat:
  - Data is written into data slot addr[offset_lp +: cnt_width_lp], taken from that beat's header.
  - The counter increments.
- Transitions:
  - Accepted beat with mem_last_i=1: go to e_send.
  - e_send with mem_ready_i=1: clear the data buffer to zero, reset the counter, go to e_collect.
- Output header equals the captured header exactly. Output data is the assembled buffer.
- Messages whose msg_type is not in payload_mask_p:
  - Arrive as a single beat; the beat data is discarded.
  - Output data is all zeros.
- Overrun: if beat stream_words_lp is accepted without mem_last_i, it is treated as last. A simulation $error is raised.
- Slots not written by any beat read as zero.

## Timing
- Reset values: mem_v_o=0, mem_o=0, counter=0, state e_collect.
- mem_ready_o is 0 while reset_n_i=0 and 1 from the first cycle after deassertion.
- Latency: mem_v_o rises the cycle after the last beat handshake.
- Minimum message period is N+1 cycles for N beats, because no beat is accepted in the e_send cycle.
- mem_o is stable while mem_v_o=1 and mem_ready_i=0.
- mem_ready_o and mem_v_o are registered and have no combinational path from the inputs.
- Reset asserted mid-message discards the partial message. Reset asserted during e_send drops the pending output.
- A single-beat message with mem_last_i=1 goes directly to e_send the next cycle.

## Configuration
- BP_STREAM_TO_LITE_REPLICATE_EN:
  - Defined: for a payload message with N beats where N < stream_words_lp, beats fill slots 0..N-1 in arrival order, ignoring addr slot bits. The N-slot block is then replicated stream_words_lp/N times across mem_o data. Sub-beat sizes replicate the single beat data to all slots.
  - Undefined: data placement is by address as described in Operation, and unwritten slots are zero.

## Test plan
Configuration: in=64, out=512.
- Reset: hold reset_n_i=0 for 3 cycles, then release -> mem_v_o=0, mem_o=0 throughout; mem_ready_o=1 on the first post-reset cycle.
- Full block: 8-beat write at addr 0x8000_0040 with beat k data=k, last on beat 7 -> one cycle later mem_v_o=1, addr=0x8000_0040, data slot k=k, size=64B.
- Wrapped fill: 8 beats starting at addr 0x...58 (slot 3), carrying slots 3,4,..,7,0,1,2 with data=slot+0x10 -> slot s holds s+0x10; header addr is 0x...58.
- Backpressure: complete a 2-beat message with mem_ready_i=0 for 5 cycles -> mem_o held constant, mem_ready_o=0, further beats stalled; handshake on cycle 6 -> mem_ready_o=1 the next cycle.
- Narrow/no-payload:
  - 8B read (not in mask), data 0xDEAD -> output data all zero.
  - 8B payload at slot 2 with data 0xAB -> with macro, all 8 slots are 0xAB; without it, only slot 2 is 0xAB.
- Abort: reset asserted after beat 3 of 8 -> no output. A following 1-beat message completes normally with no stale data.
